opll_write_scheduler: RTL and testbench
=======================================

OPLL_WRITE_SCHEDULER -- requirements
Module: opll_write_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the queued I/O write capacity (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_WAIT, default 12, meaning the clk_en ticks to idle after an address write (A0=0).
REQ-003 SHALL have parameter DATA_WAIT, default 84, meaning the clk_en ticks to idle after a data write (A0=1).
REQ-004 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset; asynchronous assertion, active-low.
REQ-006 SHALL have port clk_en, input, 1, the OPLL core clock enable, also the wait-counter tick.
REQ-007 SHALL have ports cpu_iorq, cpu_m1, cpu_wr, each input, 1, the Z80 bus strobes.
REQ-008 SHALL have ports cpu_addr, input, 8, the I/O port address, and cpu_data, input, 8, the write data.
REQ-009 SHALL have port dev_sel, input, 3, the one-hot-or-multi OPLL instance select from the I/O decoder.
REQ-010 SHALL have port chip_enabled, input, 3, the per-instance runtime enable.
REQ-011 SHALL have ports opll_cs_n, output, 3, opll_wr_n, output, 1, opll_addr, output, 1, and opll_din, output, 8, driving the shared jt2413 instances.
REQ-012 SHALL have ports busy, output, 1, FIFO non-empty or FSM not IDLE, and overflow, output, 1, sticky write-dropped flag.

Function
REQ-013 SHALL capture one write per I/O cycle, on the first clk cycle where cpu_iorq & ~cpu_m1 & cpu_wr & |(dev_sel & chip_enabled) becomes true (rising edge of the qualified strobe).
REQ-014 SHALL enqueue {mask = dev_sel & chip_enabled, a0 = cpu_addr[0], data = cpu_data}; a zero mask SHALL never be enqueued.
REQ-015 SHALL accept a push when count < FIFO_DEPTH or a pop occurs in the same cycle; otherwise it SHALL drop the write and set overflow until reset.
REQ-016 SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-017 IDLE with a non-empty FIFO SHALL pop the head in one clk cycle, regate its mask with current chip_enabled, and enter ISSUE if the result is nonzero; otherwise it SHALL discard the entry and stay in IDLE.
REQ-018 ISSUE SHALL drive opll_cs_n = ~mask, opll_wr_n = 0, opll_addr = a0 and opll_din = data, and hold them until a cycle with clk_en = 1 has completed.
REQ-019 On the edge after that clk_en cycle, the FSM SHALL deassert cs_n and wr_n to 1, load the counter with ADDR_WAIT or DATA_WAIT per a0, and enter WAIT.
REQ-020 WAIT SHALL decrement the counter on each clk_en and enter IDLE on the edge where the counter reaches 0.
REQ-021 The counter SHALL be 8 bits wide and SHALL not wrap.
REQ-022 opll_addr and opll_din SHALL hold their last values outside ISSUE.
REQ-023 Minimum latency from capture to strobe SHALL be 2 clk cycles when the FIFO is empty and the FSM is in IDLE.
REQ-024 FIFO order SHALL be strict FIFO, with pointers wrapping modulo FIFO_DEPTH.
REQ-025 A multi-bit mask SHALL strobe all selected instances simultaneously as a single transaction.

Reset
REQ-026 While reset_n = 0: opll_cs_n SHALL be 3'b111, opll_wr_n = 1, opll_addr = 0, opll_din = 0, busy = 0, overflow = 0, the FIFO SHALL be empty, the FSM SHALL be in IDLE, and the counter = 0.
REQ-027 Reset asserted mid-ISSUE or mid-WAIT SHALL deassert the strobes immediately (asynchronously) and flush all queued entries.

Structure
REQ-028 The default wait constants (12, 84) and the queue entry struct (mask 3, a0 1, data 8) SHALL live in the shared MSX package.
REQ-029 The FIFO SHALL be a separate sub-module, io_write_fifo, with push, pop, full, empty and count ports, also using asynchronous active-low reset.

Verification
REQ-030 The bench SHALL cover: with clk_en every 4 clk, write A0=0 data 0x10 then A0=1 data 0x2F to chip 0 -> two strobes with cs_n=110, and the second strobe starts ≥12 clk_en ticks after the first ends.
REQ-031 The bench SHALL cover: 9 back-to-back writes with FIFO_DEPTH=8 while WAIT is active -> 8 queued, the 9th dropped, overflow=1, and busy stays 1 until the last WAIT ends.
REQ-032 The bench SHALL cover: dev_sel=101 with chip_enabled=111, data 0x55 -> one strobe with cs_n=010 and opll_din=0x55.
REQ-033 The bench SHALL cover: a queued write to chip 1, then chip_enabled[1] cleared before issue -> entry discarded, no strobe, no WAIT.
REQ-034 The bench SHALL cover: reset_n pulsed low during ISSUE -> cs_n=111 and wr_n=1 in the same cycle, and busy=0 after release.
REQ-035 The bench SHALL cover: a long IORQ write held for 10 clk -> exactly one entry enqueued.

Source files
------------

// File: rtl/opll_write_scheduler_pkg.sv
// Shared MSX definitions for the OPLL write path: settle-time defaults,
// the queued write entry and the scheduler state encoding.
package opll_write_scheduler_pkg;

  localparam int unsigned ADDR_WAIT_DEFAULT = 12;
  localparam int unsigned DATA_WAIT_DEFAULT = 84;
  localparam int unsigned WAIT_W            = 8;

  typedef struct packed {
    logic [2:0] mask;
    logic       a0;
    logic [7:0] data;
  } io_write_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/io_write_fifo.sv
// Small power-of-two FIFO holding pending OPLL writes; a push into a full
// queue is accepted only when a pop frees a slot in the same cycle.
module io_write_fifo
  import opll_write_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  io_write_t                push_data,
  input  logic                     pop,
  output io_write_t                pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  io_write_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != DEPTH_C) || do_pop);

  assign full     = (cnt == DEPTH_C);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/opll_write_scheduler.sv
// Buffers Z80 I/O writes to the OPLL instances and replays them one at a time,
// leaving the chip's address/data settle time between strobes.
//
// state | meaning
// IDLE  | pop queue head, regate mask with chip_enabled, start strobe if any left
// ISSUE | cs_n/wr_n asserted, held until a clk_en cycle completes
// WAIT  | strobes released, counting clk_en ticks of settle time
module opll_write_scheduler
  import opll_write_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WAIT  = ADDR_WAIT_DEFAULT,
  parameter int unsigned DATA_WAIT  = DATA_WAIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       cpu_iorq,
  input  logic       cpu_m1,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_data,
  input  logic [2:0] dev_sel,
  input  logic [2:0] chip_enabled,
  output logic [2:0] opll_cs_n,
  output logic       opll_wr_n,
  output logic       opll_addr,
  output logic [7:0] opll_din,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned       CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WAIT_W-1:0] ADDR_LOAD = WAIT_W'(ADDR_WAIT);
  localparam logic [WAIT_W-1:0] DATA_LOAD = WAIT_W'(DATA_WAIT);

  sched_state_t      state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [2:0]        cs_n_d;
  logic              wr_n_d;
  logic              addr_d;
  logic [7:0]        din_d;
  logic [2:0]        live_mask;

  logic      strobe_now;
  logic      strobe_prev;
  logic      capture;
  io_write_t push_entry;
  io_write_t head;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic [CW-1:0] fifo_count;
  logic      addr_unused;

  // Only A0 selects register vs data; the rest of the port address is decoded upstream.
  assign addr_unused = ^cpu_addr[7:1];

  assign strobe_now = cpu_iorq & ~cpu_m1 & cpu_wr & (|(dev_sel & chip_enabled));
  assign capture    = strobe_now & ~strobe_prev;

  assign push_entry.mask = dev_sel & chip_enabled;
  assign push_entry.a0   = cpu_addr[0];
  assign push_entry.data = cpu_data;

  io_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (capture),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cs_n_d    = opll_cs_n;
    wr_n_d    = opll_wr_n;
    addr_d    = opll_addr;
    din_d     = opll_din;
    fifo_pop  = 1'b0;
    live_mask = head.mask & chip_enabled;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          // An instance disabled while its write sat in the queue is skipped.
          if (live_mask != 3'b000) begin
            state_d = ST_ISSUE;
            cs_n_d  = ~live_mask;
            wr_n_d  = 1'b0;
            addr_d  = head.a0;
            din_d   = head.data;
          end
        end
      end
      ST_ISSUE: begin
        if (clk_en) begin
          state_d = ST_WAIT;
          cs_n_d  = 3'b111;
          wr_n_d  = 1'b1;
          cnt_d   = opll_addr ? DATA_LOAD : ADDR_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else if (clk_en) begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      opll_cs_n   <= 3'b111;
      opll_wr_n   <= 1'b1;
      opll_addr   <= 1'b0;
      opll_din    <= 8'h00;
      strobe_prev <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opll_cs_n   <= cs_n_d;
      opll_wr_n   <= wr_n_d;
      opll_addr   <= addr_d;
      opll_din    <= din_d;
      strobe_prev <= strobe_now;
      if (capture && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  assign busy = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_opll_write_scheduler.sv
// Bench for opll_write_scheduler: directed scenarios plus randomized write
// bursts compared against an ordered list of expected OPLL strobes.
module tb_opll_write_scheduler;

  localparam int DEPTH     = 8;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_en;
  logic       cpu_iorq, cpu_m1, cpu_wr;
  logic [7:0] cpu_addr, cpu_data;
  logic [2:0] dev_sel, chip_enabled;
  logic [2:0] opll_cs_n;
  logic       opll_wr_n, opll_addr;
  logic [7:0] opll_din;
  logic       busy, overflow;

  int checks   = 0;
  int failures = 0;
  int en_period = 4;
  int en_phase  = 0;

  // observed strobes and expected strobes, in order
  logic [2:0] r_mask[$];
  logic       r_a0[$];
  logic [7:0] r_din[$];
  int         r_gap[$];
  logic [2:0] e_mask[$];
  logic       e_a0[$];
  logic [7:0] e_din[$];

  opll_write_scheduler #(
    .FIFO_DEPTH(DEPTH), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .cpu_iorq(cpu_iorq), .cpu_m1(cpu_m1), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .dev_sel(dev_sel), .chip_enabled(chip_enabled),
    .opll_cs_n(opll_cs_n), .opll_wr_n(opll_wr_n),
    .opll_addr(opll_addr), .opll_din(opll_din),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (en_period <= 0) begin
        clk_en = 1'b0;
      end else begin
        clk_en   = (en_phase == 0);
        en_phase = (en_phase + 1 >= en_period) ? 0 : en_phase + 1;
      end
    end
  end

  // Strobe monitor: records each cs_n-active window and checks its shape.
  logic       in_str = 1'b0;
  logic [2:0] s_cs;
  logic       s_a0;
  logic [7:0] s_din;
  int         s_en, s_gap;
  int         ticks = 0;
  logic       prev_valid = 1'b0;
  logic       prev_a0 = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_str = 1'b0; prev_valid = 1'b0; ticks = 0;
    end else if (opll_cs_n !== 3'b111) begin
      if (!in_str) begin
        in_str = 1'b1; s_cs = opll_cs_n; s_a0 = opll_addr; s_din = opll_din;
        s_en = 0; s_gap = ticks;
        if (prev_valid) begin
          checks++;
          if (ticks < (prev_a0 ? DATA_WAIT : ADDR_WAIT)) begin
            failures++;
            $display("FAIL wait_gap got=%0d ticks required>=%0d", ticks, prev_a0 ? DATA_WAIT : ADDR_WAIT);
          end
        end
      end else begin
        checks++;
        if (opll_cs_n !== s_cs || opll_addr !== s_a0 || opll_din !== s_din) begin
          failures++;
          $display("FAIL strobe_hold got cs_n=%b a0=%b din=%h exp cs_n=%b a0=%b din=%h",
                   opll_cs_n, opll_addr, opll_din, s_cs, s_a0, s_din);
        end
      end
      checks++;
      if (opll_wr_n !== 1'b0) begin
        failures++;
        $display("FAIL strobe_wr_n got=%b exp=0", opll_wr_n);
      end
      if (clk_en) s_en++;
    end else begin
      if (in_str) begin
        in_str = 1'b0;
        r_mask.push_back(~s_cs); r_a0.push_back(s_a0); r_din.push_back(s_din); r_gap.push_back(s_gap);
        checks++;
        if (s_en != 1) begin
          failures++;
          $display("FAIL strobe_len got=%0d clk_en cycles exp=1", s_en);
        end
        prev_valid = 1'b1; prev_a0 = s_a0; ticks = 0;
      end
      checks++;
      if (opll_wr_n !== 1'b1) begin
        failures++;
        $display("FAIL idle_wr_n got=%b exp=1", opll_wr_n);
      end
      if (clk_en) ticks++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    r_mask.delete(); r_a0.delete(); r_din.delete(); r_gap.delete();
    e_mask.delete(); e_a0.delete(); e_din.delete();
  endtask

  task automatic expect_strobe(input logic [2:0] m, input logic a0, input logic [7:0] d);
    e_mask.push_back(m); e_a0.push_back(a0); e_din.push_back(d);
  endtask

  task automatic do_write(input logic [2:0] dev, input logic a0, input logic [7:0] d,
                          input int hold, input logic m1, input logic wr);
    logic [6:0] hi;
    hi = 7'($urandom);
    cpu_iorq = 1'b1; cpu_m1 = m1; cpu_wr = wr;
    dev_sel = dev; cpu_addr = {hi, a0}; cpu_data = d;
    cyc(hold);
    cpu_iorq = 1'b0; cpu_wr = 1'b0; cpu_m1 = 1'b1; dev_sel = 3'b000;
    cyc(1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin cyc(1); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout busy=%b after %0d cycles exp=0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(3);
    checks++; if (opll_cs_n !== 3'b111) begin failures++; $display("FAIL reset_cs_n got=%b exp=111", opll_cs_n); end
    checks++; if (opll_wr_n !== 1'b1) begin failures++; $display("FAIL reset_wr_n got=%b exp=1", opll_wr_n); end
    checks++; if (opll_addr !== 1'b0) begin failures++; $display("FAIL reset_addr got=%b exp=0", opll_addr); end
    checks++; if (opll_din !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", opll_din); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    reset_n = 1'b1;
    cyc(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_addr_data();
    en_period = 4; chip_enabled = 3'b111; clear_q();
    do_write(3'b001, 1'b0, 8'h10, 1, 1'b0, 1'b1); expect_strobe(3'b001, 1'b0, 8'h10);
    do_write(3'b001, 1'b1, 8'h2F, 1, 1'b0, 1'b1); expect_strobe(3'b001, 1'b1, 8'h2F);
    wait_idle(3000, "addr_data");
    checks++;
    if (r_mask.size() != e_mask.size()) begin
      failures++; $display("FAIL addr_data_count got=%0d exp=%0d", r_mask.size(), e_mask.size());
    end
    for (int i = 0; i < e_mask.size() && i < r_mask.size(); i++) begin
      checks++;
      if (r_mask[i] !== e_mask[i] || r_a0[i] !== e_a0[i] || r_din[i] !== e_din[i]) begin
        failures++;
        $display("FAIL addr_data_entry%0d got mask=%b a0=%b din=%h exp mask=%b a0=%b din=%h",
                 i, r_mask[i], r_a0[i], r_din[i], e_mask[i], e_a0[i], e_din[i]);
      end
    end
    if (r_gap.size() >= 2) begin
      checks++;
      if (r_gap[1] < ADDR_WAIT || r_gap[1] > ADDR_WAIT + 1) begin
        failures++; $display("FAIL addr_data_gap got=%0d ticks exp=%0d..%0d", r_gap[1], ADDR_WAIT, ADDR_WAIT + 1);
      end
    end
    checks++;
    if (opll_addr !== 1'b1 || opll_din !== 8'h2F) begin
      failures++; $display("FAIL addr_data_hold got a0=%b din=%h exp a0=1 din=2f", opll_addr, opll_din);
    end
  endtask

  task automatic test_multi();
    en_period = 2; chip_enabled = 3'b111; clear_q();
    cpu_iorq = 1'b1; cpu_m1 = 1'b0; cpu_wr = 1'b1; dev_sel = 3'b101;
    cpu_addr = 8'h7C; cpu_data = 8'h55;
    @(negedge clk);
    checks++; if (opll_cs_n !== 3'b111) begin failures++; $display("FAIL multi_lat0 got=%b exp=111", opll_cs_n); end
    @(posedge clk); #1;
    cpu_iorq = 1'b0; cpu_wr = 1'b0; cpu_m1 = 1'b1; dev_sel = 3'b000;
    @(negedge clk);
    checks++; if (opll_cs_n !== 3'b111) begin failures++; $display("FAIL multi_lat1 got=%b exp=111", opll_cs_n); end
    @(negedge clk);
    checks++;
    if (opll_cs_n !== 3'b010 || opll_din !== 8'h55 || opll_wr_n !== 1'b0 || opll_addr !== 1'b0) begin
      failures++;
      $display("FAIL multi_lat2 got cs_n=%b din=%h wr_n=%b a0=%b exp cs_n=010 din=55 wr_n=0 a0=0",
               opll_cs_n, opll_din, opll_wr_n, opll_addr);
    end
    @(posedge clk); #1;
    wait_idle(2000, "multi");
    checks++;
    if (r_mask.size() != 1) begin
      failures++; $display("FAIL multi_count got=%0d exp=1", r_mask.size());
    end else begin
      checks++;
      if (r_mask[0] !== 3'b101 || r_din[0] !== 8'h55) begin
        failures++; $display("FAIL multi_entry got mask=%b din=%h exp mask=101 din=55", r_mask[0], r_din[0]);
      end
    end
  endtask

  task automatic test_regate();
    int n;
    en_period = 4; chip_enabled = 3'b111; clear_q();
    do_write(3'b001, 1'b0, 8'hA1, 1, 1'b0, 1'b1);
    do_write(3'b010, 1'b1, 8'hB2, 1, 1'b0, 1'b1);
    chip_enabled = 3'b101;
    n = 0;
    while (!(r_mask.size() >= 1 && opll_cs_n === 3'b111) && n < 200) begin cyc(1); n++; end
    n = 0;
    while (busy !== 1'b0 && n < 400) begin cyc(1); n++; end
    checks++;
    if (n > ADDR_WAIT * 4 + 8) begin
      failures++; $display("FAIL regate_busy_len got=%0d cycles exp<=%0d", n, ADDR_WAIT * 4 + 8);
    end
    cyc(40);
    checks++;
    if (r_mask.size() != 1) begin
      failures++; $display("FAIL regate_count got=%0d exp=1", r_mask.size());
    end else begin
      checks++;
      if (r_mask[0] !== 3'b001 || r_din[0] !== 8'hA1) begin
        failures++; $display("FAIL regate_entry got mask=%b din=%h exp mask=001 din=a1", r_mask[0], r_din[0]);
      end
    end
    chip_enabled = 3'b111;
  endtask

  task automatic test_long_iorq();
    en_period = 2; chip_enabled = 3'b111; clear_q();
    do_write(3'b100, 1'b1, 8'h3C, 10, 1'b0, 1'b1);
    wait_idle(3000, "long_iorq");
    cyc(5);
    checks++;
    if (r_mask.size() != 1) begin
      failures++; $display("FAIL long_iorq_count got=%0d exp=1", r_mask.size());
    end else begin
      checks++;
      if (r_mask[0] !== 3'b100 || r_a0[0] !== 1'b1 || r_din[0] !== 8'h3C) begin
        failures++; $display("FAIL long_iorq_entry got mask=%b a0=%b din=%h exp mask=100 a0=1 din=3c",
                             r_mask[0], r_a0[0], r_din[0]);
      end
    end
  endtask

  task automatic test_overflow();
    int n, tk;
    logic [2:0] m;
    logic a;
    logic [7:0] d;
    en_period = 4; chip_enabled = 3'b111; clear_q();
    do_write(3'b001, 1'b1, 8'h80, 1, 1'b0, 1'b1); expect_strobe(3'b001, 1'b1, 8'h80);
    n = 0;
    while (!(r_mask.size() >= 1 && opll_cs_n === 3'b111) && n < 200) begin cyc(1); n++; end
    for (int i = 0; i < 9; i++) begin
      m = 3'($urandom_range(1, 7)); a = 1'($urandom); d = 8'($urandom);
      if (i < DEPTH) expect_strobe(m, a, d);
      do_write(m, a, d, 1, 1'b0, 1'b1);
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_flag got=%b exp=1", overflow); end
    n = 0; tk = 0;
    while (busy === 1'b1 && n < 8000) begin
      if (r_mask.size() >= DEPTH + 1 && clk_en) tk++;
      cyc(1); n++;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL overflow_timeout busy=%b exp=0", busy); end
    checks++;
    if (r_mask.size() != DEPTH + 1) begin
      failures++; $display("FAIL overflow_count got=%0d exp=%0d", r_mask.size(), DEPTH + 1);
    end
    for (int i = 0; i < e_mask.size() && i < r_mask.size(); i++) begin
      checks++;
      if (r_mask[i] !== e_mask[i] || r_a0[i] !== e_a0[i] || r_din[i] !== e_din[i]) begin
        failures++;
        $display("FAIL overflow_entry%0d got mask=%b a0=%b din=%h exp mask=%b a0=%b din=%h",
                 i, r_mask[i], r_a0[i], r_din[i], e_mask[i], e_a0[i], e_din[i]);
      end
    end
    if (e_a0.size() == DEPTH + 1) begin
      checks++;
      if (tk < (e_a0[DEPTH] ? DATA_WAIT : ADDR_WAIT) - 1 || tk > (e_a0[DEPTH] ? DATA_WAIT : ADDR_WAIT)) begin
        failures++; $display("FAIL overflow_last_wait got=%0d ticks exp~%0d", tk, e_a0[DEPTH] ? DATA_WAIT : ADDR_WAIT);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    reset_n = 1'b0; cyc(2); reset_n = 1'b1; cyc(1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_in_issue();
    int n;
    en_period = 0; chip_enabled = 3'b111; clear_q();
    do_write(3'b010, 1'b0, 8'h11, 1, 1'b0, 1'b1);
    do_write(3'b011, 1'b1, 8'h22, 1, 1'b0, 1'b1);
    do_write(3'b111, 1'b0, 8'h33, 1, 1'b0, 1'b1);
    n = 0;
    while (opll_cs_n === 3'b111 && n < 50) begin cyc(1); n++; end
    checks++;
    if (opll_cs_n !== 3'b101 || opll_wr_n !== 1'b0) begin
      failures++; $display("FAIL rst_issue_pre got cs_n=%b wr_n=%b exp cs_n=101 wr_n=0", opll_cs_n, opll_wr_n);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (opll_cs_n !== 3'b111 || opll_wr_n !== 1'b1) begin
      failures++; $display("FAIL rst_issue_async got cs_n=%b wr_n=%b exp cs_n=111 wr_n=1", opll_cs_n, opll_wr_n);
    end
    cyc(1);
    reset_n = 1'b1;
    en_period = 2;
    cyc(1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_issue_busy got=%b exp=0", busy); end
    cyc(100);
    checks++;
    if (r_mask.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_issue_flush got strobes=%0d busy=%b exp strobes=0 busy=0", r_mask.size(), busy);
    end
  endtask

  task automatic test_random();
    int nw, kind, hold;
    logic [2:0] dev;
    logic a;
    logic [7:0] d;
    for (int round = 0; round < 8; round++) begin
      en_period = $urandom_range(1, 3);
      chip_enabled = 3'($urandom);
      clear_q();
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        dev = 3'($urandom); a = 1'($urandom); d = 8'($urandom);
        kind = $urandom_range(0, 5); hold = $urandom_range(1, 3);
        if (kind == 0) do_write(dev, a, d, hold, 1'b1, 1'b1);
        else if (kind == 1) do_write(dev, a, d, hold, 1'b0, 1'b0);
        else begin
          if ((dev & chip_enabled) != 3'b000) expect_strobe(dev & chip_enabled, a, d);
          do_write(dev, a, d, hold, 1'b0, 1'b1);
        end
        if ($urandom_range(0, 1) == 1) cyc($urandom_range(1, 20));
      end
      wait_idle(6000, "random");
      cyc(3);
      checks++;
      if (r_mask.size() != e_mask.size()) begin
        failures++; $display("FAIL random%0d_count got=%0d exp=%0d", round, r_mask.size(), e_mask.size());
      end
      for (int i = 0; i < e_mask.size() && i < r_mask.size(); i++) begin
        checks++;
        if (r_mask[i] !== e_mask[i] || r_a0[i] !== e_a0[i] || r_din[i] !== e_din[i]) begin
          failures++;
          $display("FAIL random%0d_entry%0d got mask=%b a0=%b din=%h exp mask=%b a0=%b din=%h",
                   round, i, r_mask[i], r_a0[i], r_din[i], e_mask[i], e_a0[i], e_din[i]);
        end
      end
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL random%0d_overflow got=%b exp=0", round, overflow); end
    end
    chip_enabled = 3'b111;
  endtask

  initial begin
    reset_n = 1'b0; cpu_iorq = 1'b0; cpu_m1 = 1'b1; cpu_wr = 1'b0;
    cpu_addr = 8'h00; cpu_data = 8'h00; dev_sel = 3'b000; chip_enabled = 3'b111;
    test_reset();
    test_addr_data();
    test_multi();
    test_regate();
    test_long_iorq();
    test_overflow();
    test_reset_in_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
